inst_mem: RTL and testbench

Instruction memory that answers the core's instruction-fetch port: it returns the 32-bit word at `rom_addr` whenever `rom_en` is high, in the same cycle, so the core's IF/ID register can capture it. It also contains a byte-stream loader that fills the array from a host or boot source before execution starts. While a load is running it holds the core off and returns NOP words. It sits at top level beside the core, wired to `rom_addr_out`, `rom_en` and `rom_data_in`.

---
 rtl/inst_mem_pkg.sv | 28 ++
 rtl/inst_mem_if.sv | 27 ++
 rtl/inst_mem_byte_asm.sv | 48 ++++
 rtl/inst_mem.sv | 120 ++++++++++++
 tb/tb_inst_mem.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory and its byte loader.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LANE_IDX_W = 2;
  localparam int unsigned SHIFT_W    = 5;

  localparam logic [WORD_W-1:0]     INST_NOP   = 32'h0;
  localparam logic [LANE_IDX_W-1:0] LANE_FIRST = 2'd0;
  localparam logic [LANE_IDX_W-1:0] LANE_LAST  = 2'd3;

  // Bit offset of the lane that the idx-th byte of a word lands in.
  function automatic logic [SHIFT_W-1:0] be_lane_lsb(input logic [LANE_IDX_W-1:0] idx);
    return SHIFT_W'(24) - {idx, 3'b000};
  endfunction

  function automatic logic [SHIFT_W-1:0] le_lane_lsb(input logic [LANE_IDX_W-1:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/inst_mem_if.sv
// Fetch port and byte-stream loader port of the instruction memory.
interface inst_mem_if #(
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic                  rom_en;
  logic [31:0]           rom_addr;
  logic [31:0]           rom_data;
  logic                  ld_start;
  logic                  ld_valid;
  logic [7:0]            ld_byte;
  logic                  ld_last;
  logic                  ld_ready;
  logic                  busy;
  logic                  ld_done;
  logic                  ld_error;
  logic [DEPTH_LOG2:0]   ld_words;

  modport master (
    output rom_en, rom_addr, ld_start, ld_valid, ld_byte, ld_last,
    input  rom_data, ld_ready, busy, ld_done, ld_error, ld_words
  );

  modport slave (
    input  rom_en, rom_addr, ld_start, ld_valid, ld_byte, ld_last,
    output rom_data, ld_ready, busy, ld_done, ld_error, ld_words
  );
endinterface

// File: rtl/inst_mem_byte_asm.sv
// Packs loader bytes into 32-bit words, zero-filling on an early last byte.
// Byte order is big-endian unless INST_MEM_LITTLE_ENDIAN_EN is defined.
module inst_mem_byte_asm
  import inst_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [BYTE_W-1:0] data,
  input  logic              last,
  input  logic              clear,
  output logic [WORD_W-1:0] word_c,
  output logic              word_end_c
);

  logic [LANE_IDX_W-1:0] cnt_q;
  logic [WORD_W-1:0]     word_q;
  logic [SHIFT_W-1:0]    lane_lsb_c;

`ifdef INST_MEM_LITTLE_ENDIAN_EN
  assign lane_lsb_c = le_lane_lsb(cnt_q);
`else
  assign lane_lsb_c = be_lane_lsb(cnt_q);
`endif

  // Unfilled lanes of word_q are always zero, which gives the zero-fill for free.
  assign word_c     = word_q | (WORD_W'(data) << lane_lsb_c);
  assign word_end_c = (cnt_q == LANE_LAST) | last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= LANE_FIRST;
      word_q <= '0;
    end else if (clear) begin
      cnt_q  <= LANE_FIRST;
      word_q <= '0;
    end else if (accept) begin
      if (word_end_c) begin
        cnt_q  <= LANE_FIRST;
        word_q <= '0;
      end else begin
        cnt_q  <= cnt_q + LANE_IDX_W'(1);
        word_q <= word_c;
      end
    end
  end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with a zero-latency fetch port and a byte-stream loader.
// Loader byte order follows INST_MEM_LITTLE_ENDIAN_EN (see inst_mem_byte_asm).
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input logic        clk,
  input logic        reset,
  inst_mem_if.slave  bus
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wptr_q;
  logic [CNT_W-1:0]        words_q;
  logic                    error_q;

  logic                    clear_c;
  logic                    accept_c;
  logic                    wr_en_c;
  logic                    err_set_c;
  logic [WORD_W-1:0]       word_c;
  logic                    word_end_c;
  logic [DEPTH_LOG2-1:0]   rd_idx_c;

  logic [WORD_W-1:0]       mem [DEPTH];

  inst_mem_byte_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept_c),
    .data       (bus.ld_byte),
    .last       (bus.ld_last),
    .clear      (clear_c),
    .word_c     (word_c),
    .word_end_c (word_end_c)
  );

  // Loader FSM: accepts bytes only in LOAD; a full array without ld_last is an overflow.
  always_comb begin
    state_d   = state_q;
    clear_c   = 1'b0;
    accept_c  = 1'b0;
    wr_en_c   = 1'b0;
    err_set_c = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.ld_start) begin
          state_d = ST_LOAD;
          clear_c = 1'b1;
        end
      end
      ST_LOAD: begin
        accept_c = bus.ld_valid;
        if (bus.ld_valid && word_end_c) begin
          if (words_q == CNT_W'(DEPTH)) begin
            err_set_c = 1'b1;
            state_d   = ST_DONE;
          end else begin
            wr_en_c = 1'b1;
            if (bus.ld_last) begin
              state_d = ST_DONE;
            end else if (words_q == CNT_W'(DEPTH - 1)) begin
              err_set_c = 1'b1;
              state_d   = ST_DONE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      words_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear_c) begin
        wptr_q  <= '0;
        words_q <= '0;
        error_q <= 1'b0;
      end else begin
        if (wr_en_c) begin
          wptr_q  <= wptr_q + DEPTH_LOG2'(1);
          words_q <= words_q + CNT_W'(1);
        end
        if (err_set_c) begin
          error_q <= 1'b1;
        end
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wptr_q] <= word_c;
    end
  end

  // Fetch path: word index wraps modulo the array; byte offset is ignored.
  assign rd_idx_c     = bus.rom_addr[DEPTH_LOG2+1:2];
  assign bus.rom_data = (bus.rom_en && (state_q != ST_LOAD)) ? mem[rd_idx_c] : INST_NOP;

  assign bus.ld_ready = (state_q == ST_LOAD);
  assign bus.busy     = (state_q == ST_LOAD);
  assign bus.ld_done  = (state_q == ST_DONE);
  assign bus.ld_error = error_q;
  assign bus.ld_words = words_q;

  wire unused_addr_bits = &{1'b0, bus.rom_addr[31:DEPTH_LOG2+2], bus.rom_addr[1:0]};

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: directed steps with random images against a byte-level model.
module tb_inst_mem;

  localparam int unsigned BIG_LOG2   = 10;
  localparam int unsigned SMALL_LOG2 = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_mem_if #(.DEPTH_LOG2(BIG_LOG2))   bus ();
  inst_mem_if #(.DEPTH_LOG2(SMALL_LOG2)) sbus ();

  inst_mem #(.DEPTH_LOG2(BIG_LOG2))   dut   (.clk(clk), .reset(reset), .bus(bus));
  inst_mem #(.DEPTH_LOG2(SMALL_LOG2)) dut_s (.clk(clk), .reset(reset), .bus(sbus));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] big_model [1024];
  logic [7:0]  img [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Model: word w of the current image, later bytes zero when the image stops short.
  function automatic logic [31:0] img_word(input int w);
    logic [31:0] r;
    int          i;
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      i = 4 * w + k;
      if (i < img.size()) begin
`ifdef INST_MEM_LITTLE_ENDIAN_EN
        r = r | (32'(img[i]) << (8 * k));
`else
        r = r | (32'(img[i]) << (8 * (3 - k)));
`endif
      end
    end
    return r;
  endfunction

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  // Load img into the big DUT with random valid gaps; optionally pulse ld_start mid-load.
  task automatic big_load(input int gap_min, input int gap_max, input bit poke);
    int gaps;
    bus.ld_start = 1'b1;
    @(negedge clk);
    bus.ld_start = 1'b0;
    bus.rom_addr = 32'h0;
    #1;
    check("load busy", 32'(bus.busy), 32'd1);
    check("load ready", 32'(bus.ld_ready), 32'd1);
    check("load words cleared", 32'(bus.ld_words), 32'd0);
    check("load error cleared", 32'(bus.ld_error), 32'd0);
    check("load nop", bus.rom_data, 32'h0);
    for (int i = 0; i < img.size(); i++) begin
      gaps = int'($urandom_range(32'(gap_max), 32'(gap_min)));
      for (int g = 0; g < gaps; g++) begin
        bus.ld_valid = 1'b0;
        bus.ld_start = poke && (i == img.size() / 2) && (g == 0);
        @(negedge clk);
        bus.ld_start = 1'b0;
      end
      bus.ld_valid = 1'b1;
      bus.ld_byte  = img[i];
      bus.ld_last  = (i == img.size() - 1);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    for (int w = 0; w < (img.size() + 3) / 4; w++) big_model[w] = img_word(w);
  endtask

  task automatic check_big(input string tag);
    int nw;
    nw = (img.size() + 3) / 4;
    check({tag, " words"}, 32'(bus.ld_words), 32'(nw));
    check({tag, " done"}, 32'(bus.ld_done), 32'd1);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " ready"}, 32'(bus.ld_ready), 32'd0);
    check({tag, " error"}, 32'(bus.ld_error), 32'd0);
    for (int w = 0; w < nw; w++) begin
      bus.rom_addr = ($urandom & 32'hFFFF_F000) | 32'(w << 2) | ($urandom & 32'h3);
      #1;
      check($sformatf("%s w%0d", tag, w), bus.rom_data, big_model[w]);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] zf_exp;
    logic [31:0] old_w1;

    reset = 1'b0;
    bus.rom_en = 1'b0;  bus.rom_addr = 32'h0; bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_byte = 8'h0;  bus.ld_last = 1'b0;
    sbus.rom_en = 1'b0; sbus.rom_addr = 32'h0; sbus.ld_start = 1'b0;
    sbus.ld_valid = 1'b0; sbus.ld_byte = 8'h0; sbus.ld_last = 1'b0;
    repeat (2) @(negedge clk);

    check("rst rom_data", bus.rom_data, 32'h0);
    check("rst ready", 32'(bus.ld_ready), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.ld_done), 32'd0);
    check("rst error", 32'(bus.ld_error), 32'd0);
    check("rst words", 32'(bus.ld_words), 32'd0);
    check("rst small ready", 32'(sbus.ld_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic image, back to back.
    bus.rom_en = 1'b1;
    img = '{8'h24, 8'h00, 8'h00, 8'h01, 8'h3C, 8'h01, 8'h00, 8'h11};
    big_load(0, 0, 1'b0);
    check_big("basic");

    bus.rom_en = 1'b0;
    bus.rom_addr = 32'h0;
    #1;
    check("done en0 nop", bus.rom_data, 32'h0);
    bus.rom_en = 1'b1;
    bus.rom_addr = 32'h1002;
    #1;
    check("wrap 0x1002", bus.rom_data, big_model[0]);
    @(negedge clk);

    // Zero-fill on an early last byte.
    img = '{8'hAA, 8'hBB};
    big_load(0, 1, 1'b0);
`ifdef INST_MEM_LITTLE_ENDIAN_EN
    zf_exp = 32'h0000BBAA;
`else
    zf_exp = 32'hAABB0000;
`endif
    bus.rom_addr = 32'h0;
    #1;
    check("zerofill word0", bus.rom_data, zf_exp);
    check_big("zerofill");

    // Random images with back-pressure and a stray ld_start mid-load.
    for (int r = 0; r < 3; r++) begin
      rand_img(int'($urandom_range(40, 5)));
      big_load(1, 3, 1'b1);
      check_big($sformatf("rand%0d", r));
    end

    // Basic image again with fixed 3-cycle gaps.
    img = '{8'h24, 8'h00, 8'h00, 8'h01, 8'h3C, 8'h01, 8'h00, 8'h11};
    big_load(3, 3, 1'b0);
    check_big("gap3");

    // Reset after 6 bytes: word 0 is new, partial word 1 keeps its old value.
    old_w1 = big_model[1];
    rand_img(6);
    bus.ld_start = 1'b1;
    @(negedge clk);
    bus.ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_byte  = img[i];
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    big_model[0] = img_word(0);
    reset = 1'b0;
    bus.rom_en = 1'b0;
    #1;
    check("midrst rom_data", bus.rom_data, 32'h0);
    check("midrst ready", 32'(bus.ld_ready), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.ld_done), 32'd0);
    check("midrst error", 32'(bus.ld_error), 32'd0);
    check("midrst words", 32'(bus.ld_words), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.rom_en = 1'b1;
    bus.rom_addr = 32'h0;
    #1;
    check("midrst word0", bus.rom_data, big_model[0]);
    bus.rom_addr = 32'h4;
    #1;
    check("midrst word1 kept", bus.rom_data, old_w1);
    @(negedge clk);

    // ld_start together with ld_valid in IDLE: that byte is dropped.
    rand_img(4);
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hEE;
    @(negedge clk);
    bus.ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_byte  = img[i];
      bus.ld_last  = (i == 3);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    big_model[0] = img_word(0);
    check_big("idle start+valid");

    // Overflow on the 4-word array: 20 bytes, no ld_last.
    sbus.rom_en = 1'b1;
    rand_img(20);
    sbus.ld_start = 1'b1;
    @(negedge clk);
    sbus.ld_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sbus.ld_valid = 1'b1;
      sbus.ld_byte  = img[i];
      sbus.ld_last  = 1'b0;
      @(negedge clk);
      if (i == 14) check("ovf busy b15", 32'(sbus.busy), 32'd1);
      if (i == 15) begin
        check("ovf done b16", 32'(sbus.ld_done), 32'd1);
        check("ovf error b16", 32'(sbus.ld_error), 32'd1);
        check("ovf ready b16", 32'(sbus.ld_ready), 32'd0);
        check("ovf words b16", 32'(sbus.ld_words), 32'd4);
      end
    end
    sbus.ld_valid = 1'b0;
    check("ovf ready after", 32'(sbus.ld_ready), 32'd0);
    check("ovf words after", 32'(sbus.ld_words), 32'd4);
    check("ovf error after", 32'(sbus.ld_error), 32'd1);
    for (int w = 0; w < 4; w++) begin
      sbus.rom_addr = 32'(w << 2);
      #1;
      check($sformatf("ovf w%0d", w), sbus.rom_data, img_word(w));
    end
    sbus.rom_addr = 32'h10;
    #1;
    check("ovf wrap", sbus.rom_data, img_word(0));
    @(negedge clk);

    // Restart from DONE clears count and error.
    sbus.ld_start = 1'b1;
    @(negedge clk);
    sbus.ld_start = 1'b0;
    check("restart words", 32'(sbus.ld_words), 32'd0);
    check("restart error", 32'(sbus.ld_error), 32'd0);
    check("restart busy", 32'(sbus.busy), 32'd1);
    check("restart done", 32'(sbus.ld_done), 32'd0);
    rand_img(3);
    for (int i = 0; i < 3; i++) begin
      sbus.ld_valid = 1'b1;
      sbus.ld_byte  = img[i];
      sbus.ld_last  = (i == 2);
      @(negedge clk);
    end
    sbus.ld_valid = 1'b0;
    sbus.ld_last  = 1'b0;
    sbus.rom_addr = 32'h0;
    #1;
    check("restart words end", 32'(sbus.ld_words), 32'd1);
    check("restart error end", 32'(sbus.ld_error), 32'd0);
    check("restart done end", 32'(sbus.ld_done), 32'd1);
    check("restart word0", sbus.rom_data, img_word(0));
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
